// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry
// and the write-request bundle.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_WORDS  = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO holding pending
// register-file writes for one requester.
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int W     = $bits(rf_wr_req_t),
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // extra pointer bit tells full from empty
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // pointer update; reset discards all entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
      if (do_pop)
        rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

  // storage needs no reset: empty gates its use
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file
// write port between two queued requesters.
module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int DATA_W     = RF_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0_Valid,
  output logic              Req0_Ready,
  input  logic [ADDR_W-1:0] Req0_Addr,
  input  logic [DATA_W-1:0] Req0_Data,
  input  logic              Req1_Valid,
  output logic              Req1_Ready,
  input  logic [ADDR_W-1:0] Req1_Addr,
  input  logic [DATA_W-1:0] Req1_Data,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  output logic              Busy
);

  localparam int W = ADDR_W + DATA_W;

  logic         full0, empty0;
  logic         full1, empty1;
  logic [W-1:0] head0, head1;
  logic         push0, push1;
  logic         grant0, grant1;
  logic         last_grant;

  // Ready comes from registered occupancy only
  assign Req0_Ready = !full0 && !Reset;
  assign Req1_Ready = !full1 && !Reset;
  assign push0 = Req0_Valid && Req0_Ready;
  assign push1 = Req1_Valid && Req1_Ready;

  rf_wr_fifo #(
    .W(W), .DEPTH(FIFO_DEPTH)
  ) u_fifo0 (
    .clk(Clk), .rst(Reset),
    .push(push0), .pop(grant0),
    .din({Req0_Addr, Req0_Data}),
    .full(full0), .empty(empty0),
    .head(head0)
  );

  rf_wr_fifo #(
    .W(W), .DEPTH(FIFO_DEPTH)
  ) u_fifo1 (
    .clk(Clk), .rst(Reset),
    .push(push1), .pop(grant1),
    .din({Req1_Addr, Req1_Data}),
    .full(full1), .empty(empty1),
    .head(head1)
  );

  // on a tie, favour whoever lost last time
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!empty0 && !empty1) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = !empty0;
      grant1 = !empty1;
    end
  end

  // registered write port and last-grant pointer
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      W_Addr     <= '0;
      W_Data     <= '0;
      Write_Reg  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      Write_Reg <= grant0 || grant1;
      if (grant0) begin
        {W_Addr, W_Data} <= head0;
        last_grant       <= 1'b0;
      end else if (grant1) begin
        {W_Addr, W_Data} <= head1;
        last_grant       <= 1'b1;
      end
    end
  end

  assign Busy = !empty0 || !empty1 || Write_Reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed checks of the write
// arbiter against a queue-based reference.
module tb_regfile_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int D  = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Req0_Valid = 1'b0;
  logic          Req1_Valid = 1'b0;
  logic [AW-1:0] Req0_Addr = '0;
  logic [AW-1:0] Req1_Addr = '0;
  logic [DW-1:0] Req0_Data = '0;
  logic [DW-1:0] Req1_Data = '0;
  logic          Req0_Ready, Req1_Ready;
  logic          Write_Reg, Busy;
  logic [AW-1:0] W_Addr;
  logic [DW-1:0] W_Data;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  regfile_write_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready),
    .Req0_Addr(Req0_Addr), .Req0_Data(Req0_Data),
    .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready),
    .Req1_Addr(Req1_Addr), .Req1_Data(Req1_Data),
    .W_Addr(W_Addr), .W_Data(W_Data),
    .Write_Reg(Write_Reg), .Busy(Busy)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // reference: per-requester queues + round robin
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q0[$];
  ent_t          q1[$];
  bit            m_last = 1'b1;
  bit            m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q0.delete();
      q1.delete();
      m_last = 1'b1;
      m_wr   = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      bit   p0, p1, g0, g1;
      ent_t e;
      p0 = Req0_Valid && (q0.size() < D);
      p1 = Req1_Valid && (q1.size() < D);
      g0 = (q0.size() > 0) && ((q1.size() == 0) || m_last);
      g1 = (q1.size() > 0) && !g0;
      m_wr = g0 || g1;
      if (g0) begin
        e = q0.pop_front();
        m_addr = e.a; m_data = e.d; m_last = 1'b0;
      end else if (g1) begin
        e = q1.pop_front();
        m_addr = e.a; m_data = e.d; m_last = 1'b1;
      end
      if (p0) q0.push_back({Req0_Addr, Req0_Data});
      if (p1) q1.push_back({Req1_Addr, Req1_Data});
    end
  end

  // compare every cycle, mid-cycle
  always @(negedge Clk) begin
    if (!Reset) begin
      chk("write_reg", 64'(Write_Reg), 64'(m_wr));
      chk("w_addr", 64'(W_Addr), 64'(m_addr));
      chk("w_data", 64'(W_Data), 64'(m_data));
      chk("ready0", 64'(Req0_Ready), 64'(q0.size() < D));
      chk("ready1", 64'(Req1_Ready), 64'(q1.size() < D));
      chk("busy", 64'(Busy),
          64'((q0.size() > 0) || (q1.size() > 0) || m_wr));
    end
  end

  // register file fed by the DUT's write port
  logic [DW-1:0] rf [32];
  int            wr_count = 0;
  always @(posedge Clk) begin
    if (Write_Reg && !Reset) begin
      rf[W_Addr] = W_Data;
      wr_count++;
    end
  end

  bit r0, r1, acc0, acc1;

  task automatic cycle();
    @(negedge Clk);
    r0 = Req0_Ready;
    r1 = Req1_Ready;
    @(posedge Clk);
    acc0 = Req0_Valid && r0 && !Reset;
    acc1 = Req1_Valid && r1 && !Reset;
    #1;
  endtask

  task automatic pulse_reset();
    #2 Reset = 1'b1;
    #4 Reset = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic rand_item(input int n);
    Req0_Addr = AW'($urandom);
    Req0_Data = $urandom;
    Req1_Addr = AW'($urandom);
    Req1_Data = $urandom;
    if (n == 0) begin end
  endtask

  int n0, n1, stray, base;
  bit saw_full;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // reset values
    #23 Reset = 1'b0;
    #1;
    chk("rst_write_reg", 64'(Write_Reg), 64'd0);
    chk("rst_w_addr", 64'(W_Addr), 64'd0);
    chk("rst_w_data", 64'(W_Data), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_ready0", 64'(Req0_Ready), 64'd1);
    chk("rst_ready1", 64'(Req1_Ready), 64'd1);
    @(posedge Clk);
    #1;

    // single write: visible only after edge k+1
    Req0_Valid = 1'b1;
    Req0_Addr = 5'd1;
    Req0_Data = 32'hFFFF_AAAA;
    cycle();
    chk("single_acc", 64'(acc0), 64'd1);
    Req0_Valid = 1'b0;
    chk("single_k", 64'(Write_Reg), 64'd0);
    cycle();
    chk("single_wr", 64'(Write_Reg), 64'd1);
    chk("single_addr", 64'(W_Addr), 64'd1);
    chk("single_data", 64'(W_Data), 64'hFFFF_AAAA);
    cycle();
    chk("single_after", 64'(Write_Reg), 64'd0);
    chk("single_rf", 64'(rf[1]), 64'hFFFF_AAAA);

    // contention from a fresh reset, tie repeated
    pulse_reset();
    Req0_Valid = 1'b1; Req1_Valid = 1'b1;
    Req0_Addr = 5'd1;  Req0_Data = 32'h1111_1111;
    Req1_Addr = 5'd30; Req1_Data = 32'hAAAA_FFFF;
    cycle();
    Req0_Addr = 5'd2;  Req0_Data = 32'h2222_2222;
    Req1_Addr = 5'd29; Req1_Data = 32'hBBBB_BBBB;
    cycle();
    Req0_Valid = 1'b0; Req1_Valid = 1'b0;
    chk("cont1_addr", 64'(W_Addr), 64'd1);
    chk("cont1_data", 64'(W_Data), 64'h1111_1111);
    cycle();
    chk("cont2_addr", 64'(W_Addr), 64'd30);
    chk("cont2_data", 64'(W_Data), 64'hAAAA_FFFF);
    cycle();
    chk("cont3_addr", 64'(W_Addr), 64'd2);
    cycle();
    chk("cont4_addr", 64'(W_Addr), 64'd29);
    chk("cont4_wr", 64'(Write_Reg), 64'd1);
    cycle();
    chk("cont_idle", 64'(Write_Reg), 64'd0);

    // backpressure: Req0 streams 8, Req1 pushes 3
    n0 = 0; n1 = 0; saw_full = 1'b0;
    base = wr_count;
    Req0_Valid = 1'b1; Req0_Addr = 5'd10;
    Req0_Data = 32'h0A00_0000;
    Req1_Valid = 1'b1; Req1_Addr = 5'd20;
    Req1_Data = 32'hB000_0000;
    for (int c = 0; c < 40 && (n0 < 8 || n1 < 3); c++) begin
      cycle();
      if (Req1_Valid && !r1) saw_full = 1'b1;
      if (acc0) begin
        n0++;
        Req0_Addr = AW'(10 + n0);
        Req0_Data = 32'h0A00_0000 + n0;
        if (n0 >= 8) Req0_Valid = 1'b0;
      end
      if (acc1) begin
        n1++;
        Req1_Addr = AW'(20 + n1);
        Req1_Data = 32'hB000_0000 + n1;
        if (n1 >= 3) Req1_Valid = 1'b0;
      end
    end
    chk("bp_pushed0", 64'(n0), 64'd8);
    chk("bp_pushed1", 64'(n1), 64'd3);
    chk("bp_ready1_low", 64'(saw_full), 64'd1);
    for (int c = 0; c < 8; c++) cycle();
    chk("bp_write_count", 64'(wr_count - base), 64'd11);
    chk("bp_last_req1", 64'(rf[22]), 64'hB000_0002);

    // same address from both requesters
    Req0_Valid = 1'b1; Req0_Addr = 5'd5;
    Req0_Data = 32'hA;
    cycle();
    Req0_Valid = 1'b0;
    Req1_Valid = 1'b1; Req1_Addr = 5'd5;
    Req1_Data = 32'hB;
    cycle();
    Req1_Valid = 1'b0;
    chk("same_first", 64'(W_Data), 64'hA);
    cycle();
    chk("same_second", 64'(W_Data), 64'hB);
    for (int c = 0; c < 3; c++) cycle();
    chk("same_rf5", 64'(rf[5]), 64'hB);

    // randomised traffic with held requests
    Req0_Valid = 1'b0; Req1_Valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      cycle();
      if (acc0 || !Req0_Valid) begin
        Req0_Valid = ($urandom_range(0, 3) != 0);
        Req0_Addr = AW'($urandom);
        Req0_Data = $urandom;
      end
      if (acc1 || !Req1_Valid) begin
        Req1_Valid = ($urandom_range(0, 2) != 0);
        Req1_Addr = AW'($urandom);
        Req1_Data = $urandom;
      end
    end

    // reset mid-operation with both queues loaded
    Req0_Valid = 1'b1; Req1_Valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      rand_item(c);
    end
    chk("pre_rst_busy", 64'(Busy), 64'd1);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_wr", 64'(Write_Reg), 64'd0);
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    chk("mid_rst_ready0", 64'(Req0_Ready), 64'd0);
    chk("mid_rst_ready1", 64'(Req1_Ready), 64'd0);
    Req0_Valid = 1'b0; Req1_Valid = 1'b0;
    #10 Reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (Write_Reg) stray++;
    end
    chk("no_stale_writes", 64'(stray), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32x32-bit register file between two independent write requesters, such as ALU writeback and load-return.
- Each requester pushes address/data pairs through a valid/ready handshake into its own small FIFO.
- A round-robin arbiter drains the two FIFOs into a registered output stage.
- That output stage drives the register file's `W_Addr`/`W_Data`/`Write_Reg` inputs directly.

## Interface
Parameters:
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, write data width
- `FIFO_DEPTH`, 2, entries per requester FIFO; power of two, ≥2

Ports:
- `Clk`  in  1  single clock, rising-edge active
- `Reset`  in  1  asynchronous, active-high reset
- `Req0_Valid`  in  1  requester 0 has a write to push
- `Req0_Ready`  out  1  requester 0 FIFO can accept
- `Req0_Addr`  in  ADDR_W  requester 0 target register
- `Req0_Data`  in  DATA_W  requester 0 write data
- `Req1_Valid` / `Req1_Ready` / `Req1_Addr` / `Req1_Data`: same as requester 0, for requester 1
- `W_Addr`  out  ADDR_W  to register file write address
- `W_Data`  out  DATA_W  to register file write data
- `Write_Reg`  out  1  to register file write enable
- `Busy`  out  1  any FIFO non-empty or `Write_Reg` high

## Operation
- **Push:** a transfer occurs on a rising `Clk` edge when `ReqN_Valid && ReqN_Ready`.
  - `ReqN_Ready` = FIFO N not full. It is derived from the registered occupancy only, so there is no combinational path from Valid to Ready.
  - A push into a full FIFO is impossible; the requester must hold Valid/Addr/Data stable until Ready.
- **Arbitration:** each cycle, the arbiter examines the two FIFO heads.
  - If only one FIFO is non-empty, it is granted.
  - If both are non-empty, the requester not granted last time wins.
  - The winner's head pops at the next edge. The last-grant pointer updates only on an actual grant.
- **Output stage:** on a grant, `W_Addr`/`W_Data` load the popped entry at the edge, and `Write_Reg` is set to 1. With no grant, `Write_Reg` is 0 and `W_Addr`/`W_Data` hold their previous values.
- **Ordering:**
  - Writes from one requester commit in push order.
  - Writes from different requesters to the same address commit in grant order; no merging or cancellation.
- **Address 0:** not special; it is written like any other register.
- **Reset:** asynchronous assertion at any time has the following effects.
  - Both FIFOs are emptied and pending writes are discarded.
  - The last-grant pointer is set to 1, so requester 0 wins the first tie.
  - `Write_Reg`=0, `W_Addr`=0, `W_Data`=0, `Busy`=0.
  - `Req0_Ready`=`Req1_Ready`=1 after reset; Ready is forced to 0 while Reset is high.

## Timing
- **Latency:** a push accepted at edge k yields `Write_Reg`=1 with that entry during the cycle after edge k+1 (best case, no contention). The register file commits it at edge k+2.
- **Throughput:** one register-file write per cycle sustained. Each requester gets ≥1 grant every 2 cycles under full contention.
- **Simultaneous push and pop on the same FIFO:** occupancy is unchanged. A FIFO that is full at the start of the cycle still shows Ready=0 that cycle; there is no bypass.
- **Simultaneous pushes on both requesters:** both accepted if both are Ready.
- **Pointer wrap:** FIFO read/write pointers wrap modulo `FIFO_DEPTH`. Full/empty are distinguished by an extra pointer bit or an occupancy counter.
- **Reset deassertion:** the first push can be accepted at the first rising edge after Reset falls.

## Structure
- **Shared package `rf_pkg`:** `RF_ADDR_W`=5, `RF_DATA_W`=32, `RF_WORDS`=32, and the write-request struct {addr, data}. The register file and this block both import it.
- **Sub-module `rf_wr_fifo`:** a parameterised synchronous FIFO instantiated twice, with ports push/pop/full/empty/head. Arbiter and output register live in the top module.

## Test plan
- **Reset values:** hold Reset=1, then release → `Write_Reg`=0, `W_Addr`=0, `W_Data`=0, `Busy`=0, both Ready=1.
- **Single write:** one push on Req0 (addr 1, 0xFFFF_AAAA) at edge k → `Write_Reg`=1, `W_Addr`=1, `W_Data`=0xFFFF_AAAA after edge k+1 only. A register file instance then reads 0xFFFF_AAAA at addr 1.
- **Contention:** both requesters push at the same edge (Req0: addr 1, 0x1111_1111; Req1: addr 30, 0xAAAA_FFFF) → Req0 granted first, Req1 next cycle. Repeating the tie then grants Req1 first.
- **Backpressure:** Req1 pushes 3 back-to-back while Req0 streams continuously → Req1_Ready drops to 0 when its FIFO is full. Every accepted entry later appears exactly once, in order, with none lost or duplicated.
- **Same-address ordering:** Req0 writes addr 5 = 0xA, then Req1 writes addr 5 = 0xB one cycle later → commits occur in grant order, and the final register 5 = 0xB.
- **Reset mid-operation:** assert Reset asynchronously (between edges) with both FIFOs holding entries → `Write_Reg` drops immediately and no queued write ever appears after release.
